simon_pipe_stage: RTL and testbench
===================================

Name: simon_pipe_stage

Overview:
Parametrised, registered pipeline stage for the SIMON block-cipher family (word size N, key words M). Each stage applies R unrolled rounds to a 2N-bit state, advances the M-word key schedule in step, and registers the result behind a valid/ready handshake. Stages chain to form a full encryptor, e.g. 32 stages of R=1 or 8 stages of R=4 for SIMON32/64. A round-index sideband lets a final partial stage pass through once the total round count T is reached.

Parameters:
N, 16, word size in bits (16/24/32/48/64)
M, 4, key words (2, 3 or 4)
Z_SEQ, 0, z constant sequence select (0..4)
T, 32, total cipher rounds; rounds with index >= T are bypassed
R, 1, rounds unrolled per stage (1..T)
TAG_W, 1, user sideband width, carried unchanged
RW, 7 (localparam), round-index width, $clog2(T+1) rounded up to 7 minimum

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream data valid
in_ready  out  1  stage can accept
in_round  in  RW  index of next round to apply
in_key  in  M*N  key words; word i at [N*i +: N]; word 0 = current round key
in_state  in  2N  {x,y}; x = [2N-1:N]
in_tag  in  TAG_W  sideband
out_valid  out  1  output register valid
out_ready  in  1  downstream accepts
out_round  out  RW  in_round + rounds applied
out_key  out  M*N  key words advanced by rounds applied
out_state  out  2N  state after rounds applied
out_tag  out  TAG_W  registered in_tag

Behaviour:
- Reset: out_valid=0; out_state, out_key, out_round, out_tag = 0; in_ready=1 the cycle after rst deasserts.
- Handshake: in_ready = !out_valid || out_ready (combinational). Transfer in on in_valid&&in_ready; out on out_valid&&out_ready.
- Load: on input transfer, all out_* registered from the combinational R-round result; out_valid=1. Latency 1 clk.
- Hold: out_valid && !out_ready -> all outputs stable, in_ready=0.
- Drain: out transfer without input transfer -> out_valid=0; data regs hold their value.
- Simultaneous in/out transfer: new data loaded, out_valid stays 1; full throughput 1 item/clk.
- Round r (0..R-1), idx = in_round+r: if idx < T apply round, else pass state/key/idx unchanged.
- Round: f(x) = (rotl1 x & rotl8 x) ^ rotl2 x; x' = y ^ f(x) ^ k0; y' = x.
- Key step, c = 2^N-4, zb = z[Z_SEQ][idx mod 62]:
  M=4: t = rotr3 k3 ^ k1; t ^= rotr1 t; knew = c ^ k0 ^ t ^ zb.
  M=3: t = rotr3 k2; t ^= rotr1 t; knew = c ^ k0 ^ t ^ zb.
  M=2: t = rotr3 k1; t ^= rotr1 t; knew = c ^ k0 ^ t ^ zb.
  Key words shift down: word i <- word i+1; word M-1 <- knew.
- out_round = min(in_round+R, max(in_round,T)); no wrap; in_round > T passes through unchanged.
- rst mid-operation: in-flight item discarded; out_valid=0 next clk regardless of out_ready.
- Illegal N/M/Z_SEQ combination: elaboration-time $error.

Decomposition:
- simon_pkg: the five 62-bit z constants (bit 0 = first sequence element), rotl/rotr functions, round_fn and key_step functions parametrised via N.
- Sub-module simon_round_unit (combinational: one round + key step + bypass on idx>=T), instantiated R times via generate inside simon_pipe_stage.

Test Plan:
- R=1, key 0x1918111009080100, state 0x65656877, round 0 -> out_state 0xBCA26565, out_key 0x71C3191811100908, out_round 1, one clk later.
- Chain of 32 R=1 stages, same inputs -> final out_state 0xC69BE9BB, out_round 32, latency 32 clk.
- R=4, T=32, in_round 30 -> exactly rounds 30,31 applied; out_round 32; state matches 2-round reference model.
- Backpressure: stream 8 random items, out_ready held 0 for 5 clks mid-stream -> in_ready=0 while held, outputs stable, no loss/duplication, order preserved.
- Back-to-back with out_ready=1 -> in_ready stays 1, one output per clk; tag 1 in -> tag 1 out.
- rst asserted while out_valid=1, out_ready=0 -> next clk out_valid=0, out_state=0, in_ready=1.

Source files
------------

// File: rtl/simon_pkg.sv
// ============================================================================
// Module   : simon_pkg
// Brief    : SIMON z constants, rotations and round / key-step functions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package simon_pkg;

    localparam int MAX_N = 64;
    localparam int Z_LEN = 62;

    typedef logic [MAX_N-1:0] word_t;

    function automatic logic [Z_LEN-1:0] rev62(input logic [Z_LEN-1:0] v);
        logic [Z_LEN-1:0] r;
        for (int i = 0; i < Z_LEN; i++) begin
            r[i] = v[Z_LEN-1-i];
        end
        return r;
    endfunction

    // Written first-element-leftmost for readability; Z_CONST has bit 0 = first element.
    localparam logic [Z_LEN-1:0] Z_MSB_FIRST [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    localparam logic [Z_LEN-1:0] Z_CONST [5] = '{
        rev62(Z_MSB_FIRST[0]), rev62(Z_MSB_FIRST[1]), rev62(Z_MSB_FIRST[2]),
        rev62(Z_MSB_FIRST[3]), rev62(Z_MSB_FIRST[4])
    };

    function automatic bit simon_cfg_legal(input int n, input int m, input int z);
        case (n)
            16:      return (m == 4 && z == 0);
            24:      return (m == 3 && z == 0) || (m == 4 && z == 1);
            32:      return (m == 3 && z == 2) || (m == 4 && z == 3);
            48:      return (m == 2 && z == 2) || (m == 3 && z == 3);
            64:      return (m == 2 && z == 2) || (m == 3 && z == 3) || (m == 4 && z == 4);
            default: return 1'b0;
        endcase
    endfunction

    function automatic word_t mask_n(input int unsigned n);
        return (n >= MAX_N) ? {MAX_N{1'b1}} : ((word_t'(1) << n) - word_t'(1));
    endfunction

    // Operands are zero-extended N-bit words held in a MAX_N container.
    function automatic word_t rotl(input word_t x, input int unsigned s, input int unsigned n);
        return ((x << s) | (x >> (n - s))) & mask_n(n);
    endfunction

    function automatic word_t rotr(input word_t x, input int unsigned s, input int unsigned n);
        return rotl(x, n - s, n);
    endfunction

    function automatic word_t round_fn(input word_t x, input word_t y, input word_t k,
                                       input int unsigned n);
        return y ^ ((rotl(x, 1, n) & rotl(x, 8, n)) ^ rotl(x, 2, n)) ^ k;
    endfunction

    // klast is key word M-1; k1 only enters the mix for four-word keys.
    function automatic word_t key_step(input word_t k0, input word_t k1, input word_t klast,
                                       input int unsigned m, input int unsigned n,
                                       input logic zb);
        word_t t;
        t = rotr(klast, 3, n);
        if (m == 4) begin
            t = t ^ k1;
        end
        t = t ^ rotr(t, 1, n);
        return (mask_n(n) ^ word_t'(3)) ^ k0 ^ t ^ word_t'(zb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/simon_round_unit.sv
// ============================================================================
// Module   : simon_round_unit
// Brief    : Combinational SIMON round plus key step, bypassed once idx >= T.
// Revision : 1.0
// ============================================================================
`default_nettype none

module simon_round_unit
    import simon_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 4,
    parameter int Z_SEQ = 0,
    parameter int T     = 32,
    parameter int RW    = 7
) (
    input  logic [RW-1:0]  idx_i,
    input  logic [M*N-1:0] key_i,
    input  logic [2*N-1:0] state_i,
    output logic [RW-1:0]  idx_o,
    output logic [M*N-1:0] key_o,
    output logic [2*N-1:0] state_o
);

    logic          w_active;
    logic [5:0]    w_zidx;
    logic          w_zb;
    logic [N-1:0]  w_x;
    logic [N-1:0]  w_y;
    logic [N-1:0]  w_k0;
    logic [N-1:0]  w_k1;
    logic [N-1:0]  w_klast;
    logic [N-1:0]  w_xn;
    logic [N-1:0]  w_knew;

    assign w_active = (idx_i < RW'(T));
    assign w_zidx   = 6'(idx_i % RW'(Z_LEN));
    assign w_zb     = Z_CONST[Z_SEQ][w_zidx];

    assign w_x     = state_i[2*N-1:N];
    assign w_y     = state_i[N-1:0];
    assign w_k0    = key_i[0 +: N];
    assign w_k1    = key_i[N +: N];
    assign w_klast = key_i[N*(M-1) +: N];

    assign w_xn   = N'(round_fn(word_t'(w_x), word_t'(w_y), word_t'(w_k0), N));
    assign w_knew = N'(key_step(word_t'(w_k0), word_t'(w_k1), word_t'(w_klast), M, N, w_zb));

    always_comb begin
        idx_o   = idx_i;
        key_o   = key_i;
        state_o = state_i;
        if (w_active) begin
            idx_o   = idx_i + RW'(1);
            key_o   = {w_knew, key_i[M*N-1:N]};
            state_o = {w_xn, w_x};
        end
    end

endmodule

`default_nettype wire

// File: rtl/simon_pipe_stage.sv
// ============================================================================
// Module   : simon_pipe_stage
// Brief    : Registered SIMON stage applying R unrolled rounds behind valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module simon_pipe_stage
    import simon_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 4,
    parameter int Z_SEQ = 0,
    parameter int T     = 32,
    parameter int R     = 1,
    parameter int TAG_W = 1,
    localparam int RW   = ($clog2(T + 1) > 7) ? $clog2(T + 1) : 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RW-1:0]    in_round,
    input  logic [M*N-1:0]   in_key,
    input  logic [2*N-1:0]   in_state,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_round,
    output logic [M*N-1:0]   out_key,
    output logic [2*N-1:0]   out_state,
    output logic [TAG_W-1:0] out_tag
);

    if (!simon_cfg_legal(N, M, Z_SEQ)) begin : g_bad_cfg
        $error("simon_pipe_stage: illegal N/M/Z_SEQ combination %0d/%0d/%0d", N, M, Z_SEQ);
    end

    if (R < 1 || R > T) begin : g_bad_r
        $error("simon_pipe_stage: R=%0d outside 1..T", R);
    end

    logic [RW-1:0]    w_idx   [R+1];
    logic [M*N-1:0]   w_key   [R+1];
    logic [2*N-1:0]   w_state [R+1];

    assign w_idx[0]   = in_round;
    assign w_key[0]   = in_key;
    assign w_state[0] = in_state;

    for (genvar g = 0; g < R; g++) begin : g_round
        simon_round_unit #(
            .N     (N),
            .M     (M),
            .Z_SEQ (Z_SEQ),
            .T     (T),
            .RW    (RW)
        ) u_round (
            .idx_i   (w_idx[g]),
            .key_i   (w_key[g]),
            .state_i (w_state[g]),
            .idx_o   (w_idx[g+1]),
            .key_o   (w_key[g+1]),
            .state_o (w_state[g+1])
        );
    end

    logic             out_valid_q, out_valid_d;
    logic [RW-1:0]    round_q,     round_d;
    logic [M*N-1:0]   key_q,       key_d;
    logic [2*N-1:0]   state_q,     state_d;
    logic [TAG_W-1:0] tag_q,       tag_d;
    logic             w_in_fire;
    logic             w_out_fire;

    assign in_ready   = !out_valid_q || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid_q && out_ready;

    // Data registers only move on a load so a drained slot keeps its last value.
    always_comb begin
        out_valid_d = out_valid_q;
        round_d     = round_q;
        key_d       = key_q;
        state_d     = state_q;
        tag_d       = tag_q;
        if (w_in_fire) begin
            out_valid_d = 1'b1;
            round_d     = w_idx[R];
            key_d       = w_key[R];
            state_d     = w_state[R];
            tag_d       = in_tag;
        end else if (w_out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            round_q     <= '0;
            key_q       <= '0;
            state_q     <= '0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            round_q     <= round_d;
            key_q       <= key_d;
            state_q     <= state_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_round = round_q;
    assign out_key   = key_q;
    assign out_state = state_q;
    assign out_tag   = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_simon_pipe_stage.sv
// ============================================================================
// Module   : tb_simon_pipe_stage
// Brief    : Self-checking bench for simon_pipe_stage (SIMON32/64, R=1 and R=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_simon_pipe_stage;

    typedef struct {
        logic [6:0]  rnd;
        logic [63:0] key;
        logic [31:0] st;
        logic        tag;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [6:0]  in_round = '0, out_round;
    logic [63:0] in_key = '0, out_key;
    logic [31:0] in_state = '0, out_state;
    logic        in_tag = 1'b0, out_tag;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
    logic [6:0]  in_round4 = '0, out_round4;
    logic [63:0] in_key4 = '0, out_key4;
    logic [31:0] in_state4 = '0, out_state4;
    logic        in_tag4 = 1'b0, out_tag4;

    int n_cmp = 0;
    int n_bad = 0;

    item_t q[$];
    bit    held_prev = 1'b0;
    item_t snap;

    string z0_str = "11111010001001010110000111001101111101000100101011000011100110";

    always #5 clk = ~clk;

    simon_pipe_stage #(.N(16), .M(4), .Z_SEQ(0), .T(32), .R(1), .TAG_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_round  (in_round),
        .in_key    (in_key),
        .in_state  (in_state),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_round (out_round),
        .out_key   (out_key),
        .out_state (out_state),
        .out_tag   (out_tag)
    );

    simon_pipe_stage #(.N(16), .M(4), .Z_SEQ(0), .T(32), .R(4), .TAG_W(1)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_round  (in_round4),
        .in_key    (in_key4),
        .in_state  (in_state4),
        .in_tag    (in_tag4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_round (out_round4),
        .out_key   (out_key4),
        .out_state (out_state4),
        .out_tag   (out_tag4)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    // SIMON32/64 reference: r rounds starting at it.rnd, rounds >= 32 are skipped.
    function automatic item_t model(input item_t it, input int r);
        logic [15:0] k[4];
        logic [15:0] x, y, nx, t, kn;
        int          idx;
        item_t       o;
        for (int j = 0; j < 4; j++) k[j] = it.key[16*j +: 16];
        x   = it.st[31:16];
        y   = it.st[15:0];
        idx = int'(it.rnd);
        for (int i = 0; i < r; i++) begin
            if (idx < 32) begin
                nx = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[0];
                y  = x;
                x  = nx;
                t  = rol(k[3], 13) ^ k[1];
                t  = t ^ rol(t, 15);
                kn = 16'hFFFC ^ k[0] ^ t ^ ((z0_str[idx % 62] == "1") ? 16'd1 : 16'd0);
                k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = kn;
                idx++;
            end
        end
        o     = it;
        o.rnd = 7'(idx);
        o.key = {k[3], k[2], k[1], k[0]};
        o.st  = {x, y};
        return o;
    endfunction

    // One cycle of the R=1 stage: drive at negedge, sample 1ns later, score the transfers.
    task automatic step(input bit iv, input bit ordy);
        item_t e;
        item_t it;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        if (iv) begin
            in_round = 7'($urandom_range(0, 40));
            in_key   = {$urandom, $urandom};
            in_state = $urandom;
            in_tag   = 1'($urandom);
        end
        #1;
        if (held_prev) begin
            check("hold_state", out_state, snap.st);
            check("hold_key",   out_key,   snap.key);
            check("hold_round", out_round, snap.rnd);
        end
        held_prev = 1'b0;
        if (out_valid && !out_ready) begin
            check("hold_in_ready", in_ready, 1'b0);
            held_prev = 1'b1;
            snap.st   = out_state;
            snap.key  = out_key;
            snap.rnd  = out_round;
        end
        if (ordy) check("in_ready_thru", in_ready, 1'b1);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                check("sb_state", out_state, e.st);
                check("sb_key",   out_key,   e.key);
                check("sb_round", out_round, e.rnd);
                check("sb_tag",   out_tag,   e.tag);
            end
        end
        if (in_valid && in_ready) begin
            it.rnd = in_round; it.key = in_key; it.st = in_state; it.tag = in_tag;
            q.push_back(model(it, 1));
        end
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] k;
        logic [31:0] s;
        logic [6:0]  rnd;
        item_t       it, e, e2;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_state", out_state, 32'h0);
        check("rst_out_key",   out_key,   64'h0);
        check("rst_out_round", out_round, 7'h0);
        check("rst_out_tag",   out_tag,   1'b0);
        check("rst_in_ready",  in_ready,  1'b1);

        // Full SIMON32/64 encryption by feeding the stage output back 32 times
        k = 64'h1918111009080100; s = 32'h65656877; rnd = 7'd0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            in_round = rnd; in_key = k; in_state = s; in_tag = 1'(i);
            @(posedge clk);
            #1;
            if (i == 0) begin
                check("kat_r1_state", out_state, 32'hBCA26565);
                check("kat_r1_key",   out_key,   64'h71C3191811100908);
                check("kat_r1_round", out_round, 7'd1);
                check("kat_r1_valid", out_valid, 1'b1);
            end
            if (i == 1) check("tag_one", out_tag, 1'b1);
            if (i == 32) begin
                check("bypass_state", out_state, s);
                check("bypass_key",   out_key,   k);
                check("bypass_round", out_round, 7'd32);
            end
            rnd = out_round; k = out_key; s = out_state;
            if (i == 31) begin
                check("kat_ct",       s,   32'hC69BE9BB);
                check("kat_ct_round", rnd, 7'd32);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_valid", out_valid, 1'b0);

        // R=4 stage across the T boundary: only rounds 30 and 31 apply
        @(negedge clk);
        it.rnd = 7'd30; it.key = {$urandom, $urandom}; it.st = $urandom; it.tag = 1'b0;
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        in_round4 = it.rnd; in_key4 = it.key; in_state4 = it.st; in_tag4 = it.tag;
        @(posedge clk);
        #1;
        e2 = model(it, 2);
        check("r4_edge_round", out_round4, 7'd32);
        check("r4_edge_state", out_state4, e2.st);
        check("r4_edge_key",   out_key4,   e2.key);

        @(negedge clk);
        in_round4 = 7'd33;
        @(posedge clk);
        #1;
        check("r4_over_round", out_round4, 7'd33);
        check("r4_over_state", out_state4, it.st);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            it.rnd = 7'($urandom_range(0, 36)); it.key = {$urandom, $urandom};
            it.st  = $urandom; it.tag = 1'($urandom);
            in_round4 = it.rnd; in_key4 = it.key; in_state4 = it.st; in_tag4 = it.tag;
            @(posedge clk);
            #1;
            e = model(it, 4);
            check("r4_state", out_state4, e.st);
            check("r4_key",   out_key4,   e.key);
            check("r4_round", out_round4, e.rnd);
            check("r4_tag",   out_tag4,   e.tag);
            check("r4_ready", in_ready4,  1'b1);
        end
        @(negedge clk);
        in_valid4 = 1'b0;

        // Random stream with a forced 5-cycle stall, then back-to-back traffic
        for (int c = 0; c < 150; c++) begin
            bit iv, ordy;
            iv   = ($urandom % 4) != 0;
            ordy = ($urandom % 10) < 7;
            if (c >= 60 && c < 65) begin
                iv = 1'b1; ordy = 1'b0;
            end
            step(iv, ordy);
        end
        for (int c = 0; c < 12; c++) step(1'b1, 1'b1);
        for (int c = 0; c < 3; c++)  step(1'b0, 1'b1);
        check("sb_empty", q.size(), 0);

        // Reset while holding an item under backpressure
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("pre_rst_valid", out_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid",    out_valid, 1'b0);
        check("mid_rst_state",    out_state, 32'h0);
        check("mid_rst_in_ready", in_ready,  1'b1);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        held_prev = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
